// File: rtl/wb_commit_way01_if.sv
// Bundle of signals between the two EU result registers (way0/way1), the
// writeback commit stage and the register-file write ports.
//   way0_* / way1_* : execute results tagged with a program-order ID (pID)
//   flush_i         : squash everything buffered in the commit stage
//   ready_o         : accept strobe returned to both EU registers
//   wb0_* / wb1_*   : register-file write ports (older / younger slot)
//   retired_o       : entries retired this cycle (0..2)
//   err_o           : sticky protocol error
// master = producer side (EU registers + flush source), slave = commit stage.
interface wb_commit_way01_if #(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 5,
  parameter int PID_W  = 2
);
  logic              way0_valid_i;
  logic              way0_rdWriteEnable_i;
  logic [ADDR_W-1:0] way0_rdAddr_i;
  logic [DATA_W-1:0] way0_rdData_i;
  logic [PID_W-1:0]  way0_pID_i;
  logic              way1_valid_i;
  logic              way1_rdWriteEnable_i;
  logic [ADDR_W-1:0] way1_rdAddr_i;
  logic [DATA_W-1:0] way1_rdData_i;
  logic [PID_W-1:0]  way1_pID_i;
  logic              flush_i;
  logic              ready_o;
  logic              wb0_en_o;
  logic [ADDR_W-1:0] wb0_addr_o;
  logic [DATA_W-1:0] wb0_data_o;
  logic              wb1_en_o;
  logic [ADDR_W-1:0] wb1_addr_o;
  logic [DATA_W-1:0] wb1_data_o;
  logic [1:0]        retired_o;
  logic              err_o;

  modport master (
    output way0_valid_i, way0_rdWriteEnable_i, way0_rdAddr_i, way0_rdData_i, way0_pID_i,
    output way1_valid_i, way1_rdWriteEnable_i, way1_rdAddr_i, way1_rdData_i, way1_pID_i,
    output flush_i,
    input  ready_o, wb0_en_o, wb0_addr_o, wb0_data_o,
    input  wb1_en_o, wb1_addr_o, wb1_data_o, retired_o, err_o
  );

  modport slave (
    input  way0_valid_i, way0_rdWriteEnable_i, way0_rdAddr_i, way0_rdData_i, way0_pID_i,
    input  way1_valid_i, way1_rdWriteEnable_i, way1_rdAddr_i, way1_rdData_i, way1_pID_i,
    input  flush_i,
    output ready_o, wb0_en_o, wb0_addr_o, wb0_data_o,
    output wb1_en_o, wb1_addr_o, wb1_data_o, retired_o, err_o
  );
endinterface

// File: rtl/wb_commit_way01.sv
// Writeback commit stage behind the way0/way1 EU pipeline registers.
// Results are parked in a reorder buffer indexed directly by their pID and
// retired strictly in pID order, up to two per cycle, onto two register-file
// write ports (port 0 = older, port 1 = younger).
// Ports:
//   clk     : clock
//   reset_n : synchronous active-low reset
//   bus     : wb_commit_way01_if.slave (way inputs, flush, ready, wb ports,
//             retired count, sticky error)
module wb_commit_way01 #(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 5,
  parameter int PID_W  = 2
) (
  input  logic               clk,
  input  logic               reset_n,
  wb_commit_way01_if.slave   bus
);
  localparam int DEPTH = 1 << PID_W;
  localparam int CW    = PID_W + 1;

  logic [DEPTH-1:0]  r_filled;
  logic              r_we   [DEPTH];
  logic [ADDR_W-1:0] r_addr [DEPTH];
  logic [DATA_W-1:0] r_data [DEPTH];
  logic [PID_W-1:0]  r_head;
  logic [CW-1:0]     r_count;

  logic              r_wb0_en;
  logic [ADDR_W-1:0] r_wb0_addr;
  logic [DATA_W-1:0] r_wb0_data;
  logic              r_wb1_en;
  logic [ADDR_W-1:0] r_wb1_addr;
  logic [DATA_W-1:0] r_wb1_data;
  logic [1:0]        r_retired;
  logic              r_err;

  logic              w_ready;
  logic [PID_W-1:0]  w_head1;
  logic              w_c0;
  logic              w_c1;
  logic [1:0]        w_nret;
  logic [DEPTH-1:0]  w_ret;
  logic [DEPTH-1:0]  w_busy;
  logic [DEPTH-1:0]  w_ins;
  logic              w_v0;
  logic              w_v1;
  logic              w_dup;
  logic              w_ins0;
  logic              w_ins1;
  logic              w_err_set;
  logic              w_wr0;
  logic              w_wr1;
  logic              w_same;

  assign w_ready = reset_n & ~bus.flush_i & ~r_err;

  // Commit decision is made on pre-edge state only.
  assign w_head1 = r_head + PID_W'(1);
  assign w_c0    = r_filled[r_head];
  assign w_c1    = w_c0 & r_filled[w_head1];
  assign w_nret  = {1'b0, w_c0} + {1'b0, w_c1};

  always_comb begin
    w_ret = '0;
    if (w_c0) w_ret[r_head]  = 1'b1;
    if (w_c1) w_ret[w_head1] = 1'b1;
  end

  // A slot retiring at this edge may be refilled at the same edge without
  // error; only a slot that stays occupied counts as a collision.
  assign w_busy = r_filled & ~w_ret;

  assign w_v0      = bus.way0_valid_i & w_ready;
  assign w_v1      = bus.way1_valid_i & w_ready;
  assign w_dup     = w_v0 & w_v1 & (bus.way0_pID_i == bus.way1_pID_i);
  assign w_ins0    = w_v0 & ~w_dup & ~w_busy[bus.way0_pID_i];
  assign w_ins1    = w_v1 & ~w_busy[bus.way1_pID_i];
  assign w_err_set = w_dup | (w_v0 & w_busy[bus.way0_pID_i])
                           | (w_v1 & w_busy[bus.way1_pID_i]);

  always_comb begin
    w_ins = '0;
    if (w_ins0) w_ins[bus.way0_pID_i] = 1'b1;
    if (w_ins1) w_ins[bus.way1_pID_i] = 1'b1;
  end

  assign w_wr0  = w_c0 & r_we[r_head]  & (r_addr[r_head]  != '0);
  assign w_wr1  = w_c1 & r_we[w_head1] & (r_addr[w_head1] != '0);
  // Two retiring writes to one register: only the younger one may land.
  assign w_same = w_wr0 & w_wr1 & (r_addr[r_head] == r_addr[w_head1]);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_filled   <= '0;
      r_head     <= '0;
      r_count    <= '0;
      r_wb0_en   <= 1'b0;
      r_wb0_addr <= '0;
      r_wb0_data <= '0;
      r_wb1_en   <= 1'b0;
      r_wb1_addr <= '0;
      r_wb1_data <= '0;
      r_retired  <= '0;
      r_err      <= 1'b0;
    end else if (bus.flush_i) begin
      r_filled  <= '0;
      r_head    <= '0;
      r_count   <= '0;
      r_wb0_en  <= 1'b0;
      r_wb1_en  <= 1'b0;
      r_retired <= '0;
    end else begin
      r_filled  <= (r_filled & ~w_ret) | w_ins;
      r_head    <= r_head + PID_W'(w_nret);
      r_count   <= r_count + CW'(w_ins0) + CW'(w_ins1) - CW'(w_nret);
      r_wb0_en  <= w_wr0 & ~w_same;
      r_wb1_en  <= w_wr1;
      r_retired <= w_nret;
      if (w_c0) begin
        r_wb0_addr <= r_addr[r_head];
        r_wb0_data <= r_data[r_head];
      end
      if (w_c1) begin
        r_wb1_addr <= r_addr[w_head1];
        r_wb1_data <= r_data[w_head1];
      end
      if (w_err_set) r_err <= 1'b1;
    end
  end

  // Payload needs no reset: filled bits gate every use, and inserts are
  // already blocked during reset/flush through w_ready.
  always_ff @(posedge clk) begin
    if (w_ins0) begin
      r_we[bus.way0_pID_i]   <= bus.way0_rdWriteEnable_i;
      r_addr[bus.way0_pID_i] <= bus.way0_rdAddr_i;
      r_data[bus.way0_pID_i] <= bus.way0_rdData_i;
    end
    if (w_ins1) begin
      r_we[bus.way1_pID_i]   <= bus.way1_rdWriteEnable_i;
      r_addr[bus.way1_pID_i] <= bus.way1_rdAddr_i;
      r_data[bus.way1_pID_i] <= bus.way1_rdData_i;
    end
  end

  assign bus.ready_o    = w_ready;
  assign bus.wb0_en_o   = r_wb0_en;
  assign bus.wb0_addr_o = r_wb0_addr;
  assign bus.wb0_data_o = r_wb0_data;
  assign bus.wb1_en_o   = r_wb1_en;
  assign bus.wb1_addr_o = r_wb1_addr;
  assign bus.wb1_data_o = r_wb1_data;
  assign bus.retired_o  = r_retired;
  assign bus.err_o      = r_err;
endmodule

// File: tb/tb_wb_commit_way01.sv
// Directed bench for wb_commit_way01: in-order and out-of-order retire,
// same-destination suppression, x0/non-writing results, wrap, protocol
// errors, flush and mid-operation reset.
module tb_wb_commit_way01;
  logic clk;
  logic reset_n;
  int   errors;
  int   checks;

  wb_commit_way01_if bus_if ();

  wb_commit_way01 dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_in();
    bus_if.way0_valid_i         = 1'b0;
    bus_if.way0_rdWriteEnable_i = 1'b0;
    bus_if.way0_rdAddr_i        = '0;
    bus_if.way0_rdData_i        = '0;
    bus_if.way0_pID_i           = '0;
    bus_if.way1_valid_i         = 1'b0;
    bus_if.way1_rdWriteEnable_i = 1'b0;
    bus_if.way1_rdAddr_i        = '0;
    bus_if.way1_rdData_i        = '0;
    bus_if.way1_pID_i           = '0;
    bus_if.flush_i              = 1'b0;
  endtask

  task automatic drv0(input logic we, input logic [4:0] a, input logic [63:0] d, input logic [1:0] p);
    bus_if.way0_valid_i         = 1'b1;
    bus_if.way0_rdWriteEnable_i = we;
    bus_if.way0_rdAddr_i        = a;
    bus_if.way0_rdData_i        = d;
    bus_if.way0_pID_i           = p;
  endtask

  task automatic drv1(input logic we, input logic [4:0] a, input logic [63:0] d, input logic [1:0] p);
    bus_if.way1_valid_i         = 1'b1;
    bus_if.way1_rdWriteEnable_i = we;
    bus_if.way1_rdAddr_i        = a;
    bus_if.way1_rdData_i        = d;
    bus_if.way1_pID_i           = p;
  endtask

  initial begin
    errors  = 0;
    checks  = 0;
    reset_n = 1'b0;
    clr_in();
    step();
    step();
    check("rst_ready",   64'(bus_if.ready_o),   64'd0);
    check("rst_wb0_en",  64'(bus_if.wb0_en_o),  64'd0);
    check("rst_wb1_en",  64'(bus_if.wb1_en_o),  64'd0);
    check("rst_retired", 64'(bus_if.retired_o), 64'd0);
    check("rst_err",     64'(bus_if.err_o),     64'd0);
    check("rst_wb0_addr", 64'(bus_if.wb0_addr_o), 64'd0);
    reset_n = 1'b1;
    #1;
    check("rel_ready", 64'(bus_if.ready_o), 64'd1);

    // single in-order, head 0 -> 1
    drv0(1'b1, 5'd5, 64'hA, 2'd0);
    step();
    clr_in();
    check("t1_no_early", 64'(bus_if.retired_o), 64'd0);
    step();
    check("t1_wb0_en",   64'(bus_if.wb0_en_o),   64'd1);
    check("t1_wb0_addr", 64'(bus_if.wb0_addr_o), 64'd5);
    check("t1_wb0_data", bus_if.wb0_data_o,      64'hA);
    check("t1_wb1_en",   64'(bus_if.wb1_en_o),   64'd0);
    check("t1_retired",  64'(bus_if.retired_o),  64'd1);
    step();
    check("t1_idle_ret", 64'(bus_if.retired_o), 64'd0);
    check("t1_idle_en",  64'(bus_if.wb0_en_o),  64'd0);

    // out-of-order: pID 2 arrives before pID 1, head 1 -> 3
    drv0(1'b1, 5'd3, 64'h33, 2'd2);
    step();
    clr_in();
    step();
    check("t2_wait_a", 64'(bus_if.retired_o), 64'd0);
    step();
    check("t2_wait_b", 64'(bus_if.retired_o), 64'd0);
    drv1(1'b1, 5'd4, 64'h44, 2'd1);
    step();
    clr_in();
    check("t2_wait_c", 64'(bus_if.retired_o), 64'd0);
    step();
    check("t2_wb0_addr", 64'(bus_if.wb0_addr_o), 64'd4);
    check("t2_wb0_data", bus_if.wb0_data_o,      64'h44);
    check("t2_wb1_addr", 64'(bus_if.wb1_addr_o), 64'd3);
    check("t2_wb1_data", bus_if.wb1_data_o,      64'h33);
    check("t2_en",       64'({bus_if.wb0_en_o, bus_if.wb1_en_o}), 64'd3);
    check("t2_retired",  64'(bus_if.retired_o),  64'd2);

    // same destination across the wrap (pID 3, 0), head 3 -> 1
    drv0(1'b1, 5'd7, 64'd1, 2'd3);
    drv1(1'b1, 5'd7, 64'd2, 2'd0);
    step();
    clr_in();
    step();
    check("t3_wb0_en",   64'(bus_if.wb0_en_o),   64'd0);
    check("t3_wb1_en",   64'(bus_if.wb1_en_o),   64'd1);
    check("t3_wb1_addr", 64'(bus_if.wb1_addr_o), 64'd7);
    check("t3_wb1_data", bus_if.wb1_data_o,      64'd2);
    check("t3_wb0_data", bus_if.wb0_data_o,      64'd1);
    check("t3_retired",  64'(bus_if.retired_o),  64'd2);

    // x0 write and non-writing result, head 1 -> 3
    drv0(1'b1, 5'd0, 64'h55, 2'd1);
    drv1(1'b0, 5'd9, 64'h66, 2'd2);
    step();
    clr_in();
    step();
    check("t4_en",       64'({bus_if.wb0_en_o, bus_if.wb1_en_o}), 64'd0);
    check("t4_retired",  64'(bus_if.retired_o),  64'd2);
    check("t4_wb0_data", bus_if.wb0_data_o,      64'h55);
    check("t4_wb1_addr", 64'(bus_if.wb1_addr_o), 64'd9);
    // head must now be 3
    drv0(1'b1, 5'd10, 64'h77, 2'd3);
    step();
    clr_in();
    step();
    check("t4_head_en",   64'(bus_if.wb0_en_o),   64'd1);
    check("t4_head_addr", 64'(bus_if.wb0_addr_o), 64'd10);
    check("t4_head_ret",  64'(bus_if.retired_o),  64'd1);

    // pair pID 0,1, head 0 -> 2
    drv0(1'b1, 5'd1, 64'h10, 2'd0);
    drv1(1'b1, 5'd2, 64'h11, 2'd1);
    step();
    clr_in();
    step();
    check("t5_pair_ret",  64'(bus_if.retired_o),  64'd2);
    check("t5_pair_addr", 64'(bus_if.wb1_addr_o), 64'd2);

    // one-per-cycle stream 2,3,0 across the wrap, head 2 -> 1
    for (int k = 0; k < 3; k++) begin
      drv0(1'b1, 5'(11 + k), 64'hB0 + 64'((2 + k) % 4), 2'((2 + k) % 4));
      step();
      if (k > 0) begin
        check("t5_strm_addr", 64'(bus_if.wb0_addr_o), 64'(11 + k - 1));
        check("t5_strm_ret",  64'(bus_if.retired_o),  64'd1);
      end
    end
    clr_in();
    step();
    check("t5_strm_last", 64'(bus_if.wb0_addr_o), 64'd13);
    check("t5_strm_data", bus_if.wb0_data_o,      64'hB0);
    check("t5_strm_en1",  64'(bus_if.wb1_en_o),   64'd0);

    // pID 2 twice while pID 1 is missing
    drv0(1'b1, 5'd20, 64'hE1, 2'd2);
    step();
    clr_in();
    check("t5_err_pre", 64'(bus_if.err_o),     64'd0);
    check("t5_wait",    64'(bus_if.retired_o), 64'd0);
    drv0(1'b1, 5'd21, 64'hE2, 2'd2);
    drv1(1'b1, 5'd22, 64'hE3, 2'd1);
    step();
    clr_in();
    check("t5_err",       64'(bus_if.err_o),     64'd1);
    check("t5_err_ready", 64'(bus_if.ready_o),   64'd0);
    drv0(1'b1, 5'd23, 64'hF3, 2'd3);
    step();
    clr_in();
    check("t5_dup_wb0a", 64'(bus_if.wb0_addr_o), 64'd22);
    check("t5_dup_wb1a", 64'(bus_if.wb1_addr_o), 64'd20);
    check("t5_dup_keep", bus_if.wb1_data_o,      64'hE1);
    check("t5_dup_ret",  64'(bus_if.retired_o),  64'd2);
    step();
    check("t5_blocked", 64'(bus_if.retired_o), 64'd0);
    bus_if.flush_i = 1'b1;
    step();
    clr_in();
    check("t5_err_flush", 64'(bus_if.err_o), 64'd1);

    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    #1;
    check("t6_err_clr", 64'(bus_if.err_o),   64'd0);
    check("t6_ready",   64'(bus_if.ready_o), 64'd1);

    // flush with pID 1,2 buffered and pID 0 missing
    drv0(1'b1, 5'd24, 64'h24, 2'd1);
    drv1(1'b1, 5'd25, 64'h25, 2'd2);
    step();
    clr_in();
    step();
    check("t6_wait", 64'(bus_if.retired_o), 64'd0);
    bus_if.flush_i = 1'b1;
    #1;
    check("t6_fl_ready", 64'(bus_if.ready_o), 64'd0);
    step();
    clr_in();
    check("t6_fl_ret", 64'(bus_if.retired_o), 64'd0);
    drv0(1'b1, 5'd30, 64'h30, 2'd0);
    step();
    clr_in();
    step();
    check("t6_post_ret",  64'(bus_if.retired_o),  64'd1);
    check("t6_post_addr", 64'(bus_if.wb0_addr_o), 64'd30);
    check("t6_post_en1",  64'(bus_if.wb1_en_o),   64'd0);

    // reset while pID 1 is pending
    drv0(1'b1, 5'd31, 64'h31, 2'd1);
    step();
    clr_in();
    reset_n = 1'b0;
    step();
    check("t6_rst_en",   64'(bus_if.wb0_en_o),   64'd0);
    check("t6_rst_addr", 64'(bus_if.wb0_addr_o), 64'd0);
    reset_n = 1'b1;
    step();
    check("t6_rst_ret", 64'(bus_if.retired_o), 64'd0);
    check("t6_rst_en2", 64'(bus_if.wb0_en_o),  64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
